instr_fetch: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Maintains the program counter and reads 16-bit words from instruction memory over a req/ack handshake.
- For two-word instructions (instruction bit 15 set), also fetches the trailing immediate word.
- Presents the instruction, immediate and PC to the decoder behind a valid/ready handshake. Handles control-flow redirects from execute.

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants: FSM state encodings, instruction format
// bit positions and PC arithmetic helpers.
package instr_fetch_pkg;

  // Fetch FSM states (2-bit encodings).
  typedef enum logic [1:0] {
    FETCH_S_REQ1 = 2'b00,  // fetch the first instruction word
    FETCH_S_REQ2 = 2'b01,  // fetch the trailing immediate word
    FETCH_S_OUT  = 2'b10   // bundle presented to the decoder
  } fetch_state_t;

  // Instruction bit that marks a two-word (instruction + immediate) bundle.
  localparam int unsigned INSTR_TWO_WORD_BIT = 15;

  // Instruction addresses are halfword aligned; bit 0 is always dropped.
  localparam logic [15:0] PC_ALIGN_MASK = 16'hFFFE;

  // Byte distance between consecutive 16-bit words.
  localparam logic [15:0] PC_STEP = 16'd2;

  // Address of the following word, wrapping modulo 2^16.
  function automatic logic [15:0] next_word_addr(input logic [15:0] addr);
    return addr + PC_STEP;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, reads 16-bit words over
// a req/ack memory port, gathers the optional immediate word and hands the
// bundle to the decoder over valid/ready. Redirects from execute discard any
// in-flight work; a request already on the bus is allowed to complete and
// its data is thrown away (flush) so the memory handshake is never broken.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instruction,
  output logic [15:0] imm_word,
  output logic        two_word,
  output logic [15:0] instr_pc
);

  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

  fetch_state_t state_reg, state_next;
  logic [15:0]  pc_reg, pc_next;
  logic         flush_reg, flush_next;
  logic         mem_req_reg, mem_req_next;
  logic [15:0]  mem_addr_reg, mem_addr_next;
  logic [15:0]  instruction_reg, instruction_next;
  logic [15:0]  imm_word_reg, imm_word_next;
  logic         two_word_reg, two_word_next;
  logic [15:0]  instr_pc_reg, instr_pc_next;

  logic         ack_taken;
  logic [15:0]  redirect_target;

  // An ack only counts while our request is actually on the bus.
  assign ack_taken       = mem_req_reg & mem_ack;
  assign redirect_target = redirect_pc & PC_ALIGN_MASK;

  // State and datapath registers; reset drops everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= FETCH_S_REQ1;
      pc_reg          <= RESET_PC_ALIGNED;
      flush_reg       <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= RESET_PC_ALIGNED;
      instruction_reg <= 16'h0000;
      imm_word_reg    <= 16'h0000;
      two_word_reg    <= 1'b0;
      instr_pc_reg    <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      flush_reg       <= flush_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
      instruction_reg <= instruction_next;
      imm_word_reg    <= imm_word_next;
      two_word_reg    <= two_word_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  // Next-state, PC update, bundle capture and memory request generation.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    flush_next       = flush_reg;
    instruction_next = instruction_reg;
    imm_word_next    = imm_word_reg;
    two_word_next    = two_word_reg;
    instr_pc_next    = instr_pc_reg;

    case (state_reg)
      FETCH_S_REQ1, FETCH_S_REQ2: begin
        if (redirect_en) begin
          // A request still waiting for its ack must run to completion;
          // remember to drop its data. Otherwise nothing is outstanding.
          pc_next    = redirect_target;
          state_next = FETCH_S_REQ1;
          flush_next = mem_req_reg & ~mem_ack;
        end else if (ack_taken) begin
          if (flush_reg) begin
            // Wrong-path data: discard and start fetching at the new pc.
            flush_next = 1'b0;
            state_next = FETCH_S_REQ1;
          end else if (state_reg == FETCH_S_REQ1) begin
            instruction_next = mem_rdata;
            instr_pc_next    = pc_reg;
            pc_next          = next_word_addr(pc_reg);
            if (mem_rdata[INSTR_TWO_WORD_BIT]) begin
              two_word_next = 1'b1;
              state_next    = FETCH_S_REQ2;
            end else begin
              two_word_next = 1'b0;
              imm_word_next = 16'h0000;
              state_next    = FETCH_S_OUT;
            end
          end else begin
            imm_word_next = mem_rdata;
            pc_next       = next_word_addr(pc_reg);
            state_next    = FETCH_S_OUT;
          end
        end
      end

      FETCH_S_OUT: begin
        // Redirect wins over a same-cycle ready: the bundle is wrong-path.
        if (redirect_en) begin
          pc_next    = redirect_target;
          state_next = FETCH_S_REQ1;
        end else if (instr_ready) begin
          state_next = FETCH_S_REQ1;
        end
      end

      default: begin
        state_next = FETCH_S_REQ1;
        flush_next = 1'b0;
      end
    endcase

    // Request is raised one cycle after entering a fetch state and dropped
    // for at least one cycle after every ack, giving the 3/5-cycle cadence.
    mem_req_next = (state_reg != FETCH_S_OUT) && !ack_taken;

    // The address is frozen while a request is on the bus so it cannot move
    // under the memory; between requests it follows the upcoming pc.
    mem_addr_next = mem_req_reg ? mem_addr_reg : pc_next;
  end

  assign mem_req     = mem_req_reg;
  assign mem_addr    = mem_addr_reg;
  assign instr_valid = (state_reg == FETCH_S_OUT);
  assign instruction = instruction_reg;
  assign imm_word    = imm_word_reg;
  assign two_word    = two_word_reg;
  assign instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run.
// A memory responder serves a word-addressed image with configurable
// latency, and a program-order model predicts every bundle the decoder
// should receive (word at pc, immediate at pc+2 when bit 15 is set).
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [15:0] imm_word;
  logic        two_word;
  logic [15:0] instr_pc;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .imm_word   (imm_word),
    .two_word   (two_word),
    .instr_pc   (instr_pc)
  );

  logic [15:0] mem [0:32767];
  int          total = 0;
  int          bad = 0;
  int          n_xfer = 0;
  int          lat = 0;
  logic        rand_lat = 1'b0;

  logic [15:0] exp_pc = 16'h0000;
  logic        hold_pending = 1'b0;
  logic [15:0] h_ins, h_imm, h_pc;
  logic        h_tw;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Memory responder: acks after the chosen latency, checks the request
  // protocol, and sprinkles stray acks while no request is pending.
  initial begin
    int   cnt;
    int   cur_lat;
    logic p_pend, p_ack;
    logic [15:0] p_addr;
    cnt = 0; cur_lat = 0; p_pend = 1'b0; p_ack = 1'b0; p_addr = 16'h0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        cnt = 0;
        p_pend = 1'b0;
        p_ack = 1'b0;
      end else begin
        if (p_pend) begin
          chk("req_held", 32'(mem_req), 32'd1);
          chk("addr_held", 32'(mem_addr), 32'(p_addr));
        end
        if (p_ack) chk("req_gap_after_ack", 32'(mem_req), 32'd0);
        if (mem_req) begin
          chk("addr_aligned", 32'(mem_addr[0]), 32'd0);
          if (cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 4)) : lat;
          if (cnt >= cur_lat) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr[15:1]];
            cnt = 0;
          end else begin
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            cnt++;
          end
        end else begin
          mem_ack = ($urandom_range(0, 3) == 0);
          mem_rdata = 16'($urandom);
          cnt = 0;
        end
        p_pend = mem_req && !mem_ack;
        p_ack = mem_req && mem_ack;
        p_addr = mem_addr;
      end
    end
  end

  // Program-order reference: every transfer must be the next bundle in
  // sequence from the last redirect/reset target; held bundles must not move.
  task automatic scoreboard();
    logic [15:0] e_ins, e_imm, nxt;
    if (!rst_n) begin
      hold_pending = 1'b0;
      return;
    end
    if (hold_pending) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_words", {instruction, imm_word}, {h_ins, h_imm});
      chk("hold_pc", {15'd0, two_word, instr_pc}, {15'd0, h_tw, h_pc});
    end
    if (instr_valid) chk("no_req_while_valid", 32'(mem_req), 32'd0);
    if (redirect_en) begin
      exp_pc = redirect_pc & 16'hFFFE;
      hold_pending = 1'b0;
    end else if (instr_valid && instr_ready) begin
      e_ins = mem[exp_pc[15:1]];
      nxt = exp_pc + 16'd2;
      e_imm = e_ins[15] ? mem[nxt[15:1]] : 16'h0000;
      chk("xfer_words", {instruction, imm_word}, {e_ins, e_imm});
      chk("xfer_pc", {15'd0, two_word, instr_pc}, {15'd0, e_ins[15], exp_pc});
      exp_pc = e_ins[15] ? exp_pc + 16'd4 : nxt;
      n_xfer++;
      hold_pending = 1'b0;
    end else begin
      hold_pending = instr_valid;
      h_ins = instruction;
      h_imm = imm_word;
      h_pc = instr_pc;
      h_tw = two_word;
    end
  endtask

  // One clock: drive inputs just after the falling edge, then check.
  task automatic cycle(input logic rdy, input logic redir, input logic [15:0] tgt,
                       input logic redir_on_ack);
    @(negedge clk);
    #1;
    instr_ready = rdy;
    redirect_pc = tgt;
    redirect_en = redir | (redir_on_ack & mem_req & mem_ack);
    #1;
    scoreboard();
  endtask

  task automatic wait_req(input string tag, input logic [15:0] addr);
    int n;
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      n++;
    end while (!mem_req && n < 100);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < 100) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      n++;
    end
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  // Wait for the pending ack; the address must not move and nothing may be
  // presented to the decoder meanwhile.
  task automatic wait_ack(input string tag, input logic [15:0] addr);
    int n;
    n = 0;
    while (!(mem_req && mem_ack) && n < 100) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      chk({tag, "_no_valid"}, 32'(instr_valid), 32'd0);
      if (mem_req) chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      n++;
    end
    chk({tag, "_ack"}, 32'(mem_req && mem_ack), 32'd1);
  endtask

  task automatic chk_bundle(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                            input logic tw, input logic [15:0] pc);
    chk({tag, "_instruction"}, 32'(instruction), 32'(ins));
    chk({tag, "_imm_word"}, 32'(imm_word), 32'(imm));
    chk({tag, "_two_word"}, 32'(two_word), 32'(tw));
    chk({tag, "_instr_pc"}, 32'(instr_pc), 32'(pc));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk_bundle(tag, 16'h0000, 16'h0000, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [15:0] s_ins, s_imm, s_pc;
    logic        s_tw;
    int          acks, n;
    rst_n = 1'b1;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 16'h0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[16'h0000 >> 1] = 16'h0103;
    mem[16'h0002 >> 1] = 16'h0007;
    mem[16'h0010 >> 1] = 16'h8A05;
    mem[16'h0012 >> 1] = 16'hBEEF;
    mem[16'h0014 >> 1] = 16'h1234;
    mem[16'h0200 >> 1] = 16'h8777;
    mem[16'h0202 >> 1] = 16'h1111;
    mem[16'hFFFE >> 1] = 16'h8000;
    #1 rst_n = 1'b0;

    // Reset state and first fetch with zero-wait memory.
    lat = 0;
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 16'h0000;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h0000);
    chk("first_not_valid", 32'(instr_valid), 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk_bundle("t1", 16'h0103, 16'h0000, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t1_gap_req", 32'(mem_req), 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t1_next_req", 32'(mem_req), 32'd1);
    chk("t1_next_addr", 32'(mem_addr), 32'h0002);

    // Redirect with a same-cycle ready in S_OUT, then a two-word fetch.
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_pre_valid", 32'(instr_valid), 32'd1);
    chk("t2_pre_pc", 32'(instr_pc), 32'h0002);
    lat = 3;
    cycle(1'b1, 1'b1, 16'h0011, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_dropped", 32'(instr_valid), 32'd0);
    wait_req("t2_target", 16'h0010);
    wait_valid("t2");
    chk_bundle("t2", 16'h8A05, 16'hBEEF, 1'b1, 16'h0010);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    wait_req("t2_next", 16'h0014);

    // Backpressure: bundle held and no memory traffic for five cycles.
    wait_valid("t3");
    s_ins = instruction; s_imm = imm_word; s_pc = instr_pc; s_tw = two_word;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      chk("t3_req_low", 32'(mem_req), 32'd0);
      chk("t3_stable", {s_tw, s_pc, instruction}, {s_tw, s_pc, 16'h1234});
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t3_released", 32'(instr_valid), 32'd0);
    lat = 6;
    wait_req("t3_next", 16'h0016);

    // Redirects while a request is pending: address held, data dropped,
    // the last of several redirects wins.
    cycle(1'b0, 1'b1, 16'h0004, 1'b0);
    wait_ack("t4_flush1", 16'h0016);
    wait_req("t4_first_target", 16'h0004);
    cycle(1'b0, 1'b1, 16'h0601, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0201, 1'b0);
    lat = 2;
    wait_ack("t4_flush2", 16'h0004);
    wait_req("t4_last_wins", 16'h0200);

    // Redirect coinciding with the immediate-word ack.
    acks = 0;
    n = 0;
    while (acks < 2 && n < 50) begin
      cycle(1'b0, 1'b0, 16'h0300, acks == 1);
      chk("t5_no_valid", 32'(instr_valid), 32'd0);
      if (mem_req && mem_ack) acks++;
      n++;
    end
    chk("t5_acks_seen", 32'(acks), 32'd2);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t5_dropped", 32'(instr_valid), 32'd0);
    wait_req("t5_target", 16'h0300);

    // PC wrap: two-word instruction at FFFE takes its immediate from 0000.
    mem[16'h0000 >> 1] = 16'h5A5A;
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    wait_valid("t6");
    chk_bundle("t6", 16'h8000, 16'h5A5A, 1'b1, 16'hFFFE);
    lat = 5;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    wait_req("t6_wrap_next", 16'h0002);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Asynchronous reset while a request is waiting.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    repeat (2) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 16'h0000;

    // Randomized traffic: random latency, readiness and redirects.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
            16'($urandom), $urandom_range(0, 7) == 0);
    end
    chk("random_progress", 32'(n_xfer > 150), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
